kb_link_scheduler: RTL and testbench

//  Sits between the PS/2 keyboard interface and the UART transmitter; owns both directions of the link.

---
 rtl/kb_link_pkg.sv | 23 ++
 rtl/kb_byte_fifo.sv | 60 ++++++
 rtl/kb_link_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_kb_link_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_link_pkg.sv
// Shared constants and FSM state encodings for the keyboard link scheduler.
package kb_link_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_SEND  = 2'd1,
    U_GUARD = 2'd2,
    U_DRAIN = 2'd3
  } uart_state_e;

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_CMD  = 3'd1,
    L_ACK1 = 3'd2,
    L_DATA = 3'd3,
    L_ACK2 = 3'd4
  } led_state_e;

endpackage

// File: rtl/kb_byte_fifo.sv
// Byte-wide synchronous FIFO with a show-ahead head; push on full is ignored
// unless a pop frees a slot in the same cycle.
module kb_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/kb_link_scheduler.sv
// Keyboard link scheduler: meters keycodes from a FIFO into the UART and runs
// the PS/2 Set-LED exchange (ED, ACK, LED byte, ACK) with resend/timeout/retry.
module kb_link_scheduler
  import kb_link_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_kc_valid,
  input  logic [7:0]                  i_kc,
  output logic                        o_uart_send,
  output logic [7:0]                  o_uart_byte,
  input  logic                        i_uart_busy,
  input  logic [2:0]                  i_led_status,
  output logic                        o_host_cmd_valid,
  output logic [7:0]                  o_host_cmd,
  input  logic                        i_host_cmd_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_fifo_overflow,
  output logic                        o_led_err,
  output logic [1:0]                  o_dbg_uart_state,
  output logic [2:0]                  o_dbg_led_state
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  uart_state_e uart_q, uart_d;
  led_state_e  led_q, led_d;

  logic [7:0]    byte_q, byte_d;
  logic          overflow_q, overflow_d;
  logic [2:0]    shadow_q, shadow_d;
  logic [2:0]    pending_q, pending_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          led_err_q, led_err_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic       in_ack, kc_is_ack, kc_is_resend, kc_to_fifo, u_ready, bypass;

  // ACK/RESEND bytes are swallowed only while awaiting a keyboard reply.
  assign in_ack       = (led_q == L_ACK1) || (led_q == L_ACK2);
  assign kc_is_ack    = i_kc_valid && (i_kc == PS2_ACK);
  assign kc_is_resend = i_kc_valid && (i_kc == PS2_RESEND);
  assign kc_to_fifo   = i_kc_valid && !(in_ack && (kc_is_ack || kc_is_resend));

  // An idle link forwards a fresh byte straight to the UART so the send pulse
  // follows the keycode pulse by one cycle.
  assign u_ready   = (uart_q == U_IDLE) && !i_uart_busy;
  assign fifo_pop  = u_ready && !fifo_empty;
  assign bypass    = u_ready && fifo_empty && kc_to_fifo;
  assign fifo_push = kc_to_fifo && !bypass;

  kb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_din   (i_kc),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_count (o_fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      uart_q     <= U_IDLE;
      led_q      <= L_IDLE;
      byte_q     <= '0;
      overflow_q <= 1'b0;
      shadow_q   <= '0;
      pending_q  <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      led_err_q  <= 1'b0;
    end else begin
      uart_q     <= uart_d;
      led_q      <= led_d;
      byte_q     <= byte_d;
      overflow_q <= overflow_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      led_err_q  <= led_err_d;
    end
  end

  always_comb begin
    uart_d     = uart_q;
    byte_d     = byte_q;
    overflow_d = overflow_q || (fifo_push && fifo_full && !fifo_pop);
    unique case (uart_q)
      U_IDLE: begin
        if (fifo_pop) begin
          byte_d = fifo_head;
          uart_d = U_SEND;
        end else if (bypass) begin
          byte_d = i_kc;
          uart_d = U_SEND;
        end
      end
      U_SEND:  uart_d = U_GUARD;
      U_GUARD: uart_d = U_DRAIN;
      U_DRAIN: if (!i_uart_busy) uart_d = U_IDLE;
      default: uart_d = U_IDLE;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    led_err_d = led_err_q;
    unique case (led_q)
      L_IDLE: begin
        if (i_led_status != shadow_q) begin
          pending_d = i_led_status;
          retry_d   = '0;
          led_d     = L_CMD;
        end
      end
      L_CMD: begin
        if (i_host_cmd_done) begin
          timer_d = '0;
          led_d   = L_ACK1;
        end
      end
      L_DATA: begin
        if (i_host_cmd_done) begin
          timer_d = '0;
          led_d   = L_ACK2;
        end
      end
      L_ACK1, L_ACK2: begin
        if (kc_is_ack) begin
          if (led_q == L_ACK1) begin
            led_d = L_DATA;
          end else begin
            shadow_d = pending_q;
            led_d    = L_IDLE;
          end
        end else if (kc_is_resend) begin
          if (led_q == L_ACK1) led_d = L_CMD;
          else                 led_d = L_DATA;
        end else if (timer_q == TIMER_LAST) begin
          // Giving up adopts the pending value so a dead keyboard cannot loop us.
          if (retry_q == RETRY_MAX) begin
            led_err_d = 1'b1;
            shadow_d  = pending_q;
            led_d     = L_IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            led_d   = L_CMD;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: led_d = L_IDLE;
    endcase
  end

  // Handshakes: o_uart_send is a one-cycle strobe with o_uart_byte held until
  // the UART drops busy; o_host_cmd_valid/o_host_cmd stay asserted until the
  // one-cycle i_host_cmd_done strobe is sampled.
  always_comb begin
    o_uart_send      = (uart_q == U_SEND);
    o_uart_byte      = byte_q;
    o_host_cmd_valid = (led_q == L_CMD) || (led_q == L_DATA);
    o_host_cmd       = 8'h00;
    if (led_q == L_CMD)  o_host_cmd = PS2_CMD_SET_LED;
    if (led_q == L_DATA) o_host_cmd = {5'b0, pending_q};
  end

  assign o_fifo_overflow  = overflow_q;
  assign o_led_err        = led_err_q;
  assign o_dbg_uart_state = uart_q;
  assign o_dbg_led_state  = led_q;

endmodule

// File: tb/tb_kb_link_scheduler.sv
// Directed bench for kb_link_scheduler: keycode metering, FIFO overflow and
// the Set-LED exchange with ACK, RESEND, timeout and reset mid-sequence.
module tb_kb_link_scheduler;
  import kb_link_pkg::*;

  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 40;
  localparam int MAX_RETRY   = 3;
  localparam int HOST_DELAY  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kc_valid;
  logic [7:0] kc;
  logic       uart_send;
  logic [7:0] uart_byte;
  logic       uart_busy;
  logic [2:0] led_status;
  logic       host_cmd_valid;
  logic [7:0] host_cmd;
  logic       host_cmd_done;
  logic [3:0] fifo_count;
  logic       fifo_overflow;
  logic       led_err;
  logic [1:0] dbg_uart_state;
  logic [2:0] dbg_led_state;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ed_cyc_q[$];
  int         send_cnt  = 0;
  int         ed_cnt    = 0;
  int         neg_cyc   = 0;
  int         busy_cnt  = 0;
  int         hcnt      = 0;
  bit         hold_busy = 0;
  bit         prev_ed   = 0;

  kb_link_scheduler #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_kc_valid       (kc_valid),
    .i_kc             (kc),
    .o_uart_send      (uart_send),
    .o_uart_byte      (uart_byte),
    .i_uart_busy      (uart_busy),
    .i_led_status     (led_status),
    .o_host_cmd_valid (host_cmd_valid),
    .o_host_cmd       (host_cmd),
    .i_host_cmd_done  (host_cmd_done),
    .o_fifo_count     (fifo_count),
    .o_fifo_overflow  (fifo_overflow),
    .o_led_err        (led_err),
    .o_dbg_uart_state (dbg_uart_state),
    .o_dbg_led_state  (dbg_led_state)
  );

  // Clock / reset-independent models: UART busy for 10 cycles per byte,
  // keyboard interface finishing each host byte after HOST_DELAY cycles.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    neg_cyc++;
    if (uart_send) begin
      got_q.push_back(uart_byte);
      send_cnt++;
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    uart_busy = hold_busy || (busy_cnt != 0);

    host_cmd_done = 1'b0;
    if (!host_cmd_valid) begin
      hcnt = 0;
    end else begin
      hcnt++;
      if (hcnt == HOST_DELAY) begin
        host_cmd_done = 1'b1;
        hcnt = 0;
      end
    end

    if (host_cmd_valid && host_cmd == 8'hED && !prev_ed) begin
      ed_cnt++;
      ed_cyc_q.push_back(neg_cyc);
    end
    prev_ed = host_cmd_valid && (host_cmd == 8'hED);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_kc(input logic [7:0] b);
    kc_valid = 1'b1;
    kc       = b;
    @(negedge clk);
    kc_valid = 1'b0;
  endtask

  task automatic wait_host_valid(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = host_cmd_valid;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_led_state(input string tag, input logic [2:0] st, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (dbg_led_state == st);
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_sends(input string tag, input int n, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (send_cnt >= n);
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " uart_send"}, {31'b0, uart_send}, 32'd0);
    chk({tag, " uart_byte"}, {24'b0, uart_byte}, 32'd0);
    chk({tag, " host_valid"}, {31'b0, host_cmd_valid}, 32'd0);
    chk({tag, " host_cmd"}, {24'b0, host_cmd}, 32'd0);
    chk({tag, " fifo_count"}, {28'b0, fifo_count}, 32'd0);
    chk({tag, " overflow"}, {31'b0, fifo_overflow}, 32'd0);
    chk({tag, " led_err"}, {31'b0, led_err}, 32'd0);
  endtask

  task automatic compare_bytes(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " byte"}, {24'b0, got_q.pop_front()}, {24'b0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    kc_valid   = 1'b0;
    kc         = 8'h00;
    led_status = 3'b000;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: three back-to-back keycodes, first one forwarded on the next cycle
    got_q.delete();
    exp_q = '{8'h1C, 8'h32, 8'h21};
    kc_valid = 1'b1;
    kc       = 8'h1C;
    @(negedge clk);
    chk("t1 latency send", {31'b0, uart_send}, 32'd1);
    chk("t1 latency byte", {24'b0, uart_byte}, 32'h1C);
    kc = 8'h32;
    @(negedge clk);
    kc = 8'h21;
    @(negedge clk);
    kc_valid = 1'b0;
    chk("t1 fifo count", {28'b0, fifo_count}, 32'd2);
    wait_sends("t1 sends reached", 3, 200);
    repeat (20) @(negedge clk);
    compare_bytes("t1");

    // 2: overflow with UART held busy
    hold_busy = 1;
    repeat (3) @(negedge clk);
    base = send_cnt;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pulse_kc(8'h40 + 8'(i));
      exp_q.push_back(8'h40 + 8'(i));
    end
    chk("t2 count full", {28'b0, fifo_count}, 32'd8);
    chk("t2 no overflow yet", {31'b0, fifo_overflow}, 32'd0);
    pulse_kc(8'h48);
    chk("t2 count after 9th", {28'b0, fifo_count}, 32'd8);
    chk("t2 overflow", {31'b0, fifo_overflow}, 32'd1);
    hold_busy = 0;
    wait_sends("t2 sends reached", base + FIFO_DEPTH, 400);
    repeat (30) @(negedge clk);
    chk("t2 total sends", send_cnt - base, FIFO_DEPTH);
    compare_bytes("t2");
    chk("t2 overflow sticky", {31'b0, fifo_overflow}, 32'd1);

    // 3: normal Set-LED exchange, ACKs never reach the UART
    base = send_cnt;
    ed_cnt = 0;
    led_status = 3'b100;
    wait_host_valid("t3 cmd issued", 20);
    chk("t3 cmd byte", {24'b0, host_cmd}, 32'hED);
    wait_led_state("t3 ack1", L_ACK1, 20);
    pulse_kc(8'hFA);
    wait_host_valid("t3 data issued", 20);
    chk("t3 data byte", {24'b0, host_cmd}, 32'h04);
    wait_led_state("t3 ack2", L_ACK2, 20);
    pulse_kc(8'hFA);
    repeat (5) @(negedge clk);
    chk("t3 idle", {29'b0, dbg_led_state}, {29'b0, L_IDLE});
    chk("t3 host valid low", {31'b0, host_cmd_valid}, 32'd0);
    chk("t3 no ack to uart", send_cnt - base, 0);
    chk("t3 fifo empty", {28'b0, fifo_count}, 32'd0);
    chk("t3 ed count", ed_cnt, 1);

    // 4: RESEND after 0xED re-issues it once
    ed_cnt = 0;
    led_status = 3'b110;
    wait_host_valid("t4 cmd issued", 20);
    wait_led_state("t4 ack1", L_ACK1, 20);
    pulse_kc(8'hFE);
    wait_host_valid("t4 resend issued", 20);
    chk("t4 resend byte", {24'b0, host_cmd}, 32'hED);
    wait_led_state("t4 ack1 again", L_ACK1, 20);
    pulse_kc(8'hFA);
    wait_host_valid("t4 data issued", 20);
    chk("t4 data byte", {24'b0, host_cmd}, 32'h06);
    wait_led_state("t4 ack2", L_ACK2, 20);
    pulse_kc(8'hFA);
    repeat (5) @(negedge clk);
    chk("t4 idle", {29'b0, dbg_led_state}, {29'b0, L_IDLE});
    chk("t4 ed count", ed_cnt, 2);
    chk("t4 led_err", {31'b0, led_err}, 32'd0);
    chk("t4 no ack to uart", send_cnt - base, 0);

    // 5: keyboard never answers; 0xED spacing = HOST_DELAY + TIMEOUT_CYC
    ed_cnt = 0;
    ed_cyc_q.delete();
    led_status = 3'b111;
    wait_host_valid("t5 cmd issued", 20);
    wait_led_state("t5 back idle", L_IDLE, 8 * (TIMEOUT_CYC + HOST_DELAY + 4));
    chk("t5 ed count", ed_cnt, 1 + MAX_RETRY);
    for (int i = 1; i < ed_cyc_q.size(); i++)
      chk("t5 ed spacing", ed_cyc_q[i] - ed_cyc_q[i-1], TIMEOUT_CYC + HOST_DELAY);
    chk("t5 led_err", {31'b0, led_err}, 32'd1);
    repeat (10) @(negedge clk);
    chk("t5 stays idle", {29'b0, dbg_led_state}, {29'b0, L_IDLE});
    chk("t5 host valid low", {31'b0, host_cmd_valid}, 32'd0);

    // 6: ordinary keycode during L_ACK1 is forwarded; reset mid-sequence
    got_q.delete();
    base = send_cnt;
    led_status = 3'b001;
    wait_host_valid("t6 cmd issued", 20);
    wait_led_state("t6 ack1", L_ACK1, 20);
    pulse_kc(8'h1C);
    wait_sends("t6 keycode sent", base + 1, 20);
    chk("t6 forwarded byte", {24'b0, got_q.size() > 0 ? got_q[0] : 8'h00}, 32'h1C);
    chk("t6 still ack1", {29'b0, dbg_led_state}, {29'b0, L_ACK1});
    chk("t6 led_err sticky", {31'b0, led_err}, 32'd1);
    rst_n      = 1'b0;
    led_status = 3'b000;
    #1;
    check_all_zero("t6 async reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("t6 after reset");
    chk("t6 led idle", {29'b0, dbg_led_state}, {29'b0, L_IDLE});

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
